keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 matrix keypad: drives columns, samples rows, debounces, and reports presses.
//  It is the producer end of the game block's keypad interface: key_code/key_enable feed
//  keypad_input/keypad_enable of the game logic.
//  Codes 1..15 are note/answer codes; code 0 stays reserved for "silence".
//  The bottom-right key (position 15) is a function key, reported separately.
// PARAMETERS
//  SCAN_DIV         1000  clocks each column is driven (>=4; covers 2-flop sync + settle)
//  DEBOUNCE_FRAMES  4     consecutive identical frames needed to accept a press or release (1..15)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  row_in       in   4  keypad rows, active-low, pulled up, asynchronous
//  key_lock     in   1  game busy (music playing); used only with KEYPAD_LOCK_EN
//  col_out      out  4  column drive, active-low one-hot
//  key_code     out  4  code of the last accepted press = position+1; held until the next press
//  key_enable   out  1  1-cycle strobe, aligned with a new key_code
//  key_func     out  1  1-cycle strobe on an accepted function-key press
//  key_held     out  1  high while an accepted key is down (PRESSED or RELEASING)
//  key_release  out  1  1-cycle strobe on a debounced release
// BEHAVIOUR
//  - Reset values: col_out=4'b1110, key_code=0, all strobes=0, key_held=0; FSM=IDLE; counters=0.
//  - Reset has priority. A reset mid-operation aborts any debounce in progress and emits no strobe.
//  - row_in passes through a 2-flop synchronizer.
//  - div_cnt counts 0..SCAN_DIV-1. Synced rows are sampled at div_cnt==SCAN_DIV-1.
//    The column index then advances 0->1->2->3->0.
//  - Frame: the four column samples.
//    - Position = row*4 + col.
//    - Scan order is col 0..3, and within a column row 0..3. The first low row found wins.
//    - Extra simultaneous keys are ignored.
//  - Frame end: the sample at col 3. The FSM updates only on that edge.
//  - FSM states:
//    - IDLE: key seen -> CAND, cand=pos, cnt=1.
//    - CAND, same pos: cnt+1. When cnt reaches DEBOUNCE_FRAMES -> PRESSED and accept.
//      DEBOUNCE_FRAMES=1 accepts on the IDLE->CAND frame itself.
//    - CAND, different pos: cand=pos, cnt=1.
//    - CAND, no key: -> IDLE.
//    - PRESSED: no key -> RELEASING, cnt=1. Any key (same or rollover) -> stay.
//    - RELEASING: no key -> cnt+1. At DEBOUNCE_FRAMES -> IDLE and pulse key_release.
//    - RELEASING: any key -> PRESSED. No new press is reported.
//  - Accept:
//    - pos<15: key_code<=pos+1 and key_enable=1, in the cycle after the frame-end edge.
//    - pos==15: key_func=1, and key_code is unchanged.
//  - At most one strobe is issued per frame. Strobes are exactly 1 cycle wide.
//  - key_held rises in the same cycle as the accept strobe and falls with key_release.
//  - Counter widths: div_cnt is $clog2(SCAN_DIV); cnt is 4 bits and saturates at DEBOUNCE_FRAMES.
// CONFIGURATION
//  KEYPAD_LOCK_EN defined:
//    - An accept that occurs while key_lock=1 is swallowed: no key_enable/key_func, and key_code
//      is unchanged.
//    - The FSM still enters PRESSED, so the key must be released before it can report again.
//  KEYPAD_LOCK_EN undefined: key_lock is ignored and every accept strobes.
// STRUCTURE
//  - keypad_pkg holds:
//    - the state enum (IDLE, CAND, PRESSED, RELEASING);
//    - NUM_ROWS=4 and NUM_COLS=4;
//    - KEY_FUNC_POS=15;
//    - COL_RESET=4'b1110.
//  - Sub-module keypad_col_scanner: synchronizer, divider, column drive, frame capture.
//    It outputs frame_done, frame_hit and frame_pos[3:0].
//  - The top level holds the debounce FSM and the outputs.
// TESTING  (SCAN_DIV=4, DEBOUNCE_FRAMES=3; frame = 16 clk)
//  1. Assert reset for 2 cycles mid-frame during CAND -> col_out=1110; all outputs 0; no strobe.
//  2. Hold row1 low during col2 (pos 6) -> one key_enable with key_code=7 after the 3rd frame;
//     key_held=1.
//  3. Release after test 2 -> key_release after 3 empty frames; key_held=0; key_code stays 7.
//  4. Toggle pos 6 present/absent each frame for 10 frames -> no strobes; FSM never leaves IDLE/CAND.
//  5. Hold pos 2 (row0,col2) and pos 9 (row2,col1) together -> key_code=10.
//     Then hold pos 15 -> key_func only; key_code stays 10.
//  6. With KEYPAD_LOCK_EN: key_lock=1 and press pos 0 -> no key_enable, key_held=1.
//     Drop key_lock and press pos 0 again after release -> key_code=1.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAND,
        PRESSED,
        RELEASING
    } key_state_e;

    localparam int          NUM_ROWS     = 4;
    localparam int          NUM_COLS     = 4;
    localparam logic [3:0]  KEY_FUNC_POS = 4'd15;
    localparam logic [3:0]  COL_RESET    = 4'b1110;

    function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
        return (val >= lim) ? lim : val + 4'd1;
    endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// Column scanner: row synchronizer, scan divider, one-hot-low column drive and
// per-frame capture of the first pressed key in scan order.
module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       frame_done,
    output logic       frame_hit,
    output logic [3:0] frame_pos
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]       row_s1_q, row_s2_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_out_q, col_out_d;
    logic             hit_q, hit_d;
    logic [3:0]       pos_q, pos_d;

    logic             sample;
    logic [3:0]       row_low;
    logic             col_hit;
    logic [1:0]       row_sel;
    logic [3:0]       col_pos;

    always_comb begin
        sample  = (div_cnt_q == DIV_LAST);
        row_low = ~row_s2_q;
        col_hit = |row_low;
        row_sel = 2'd0;
        // Walk downward so the lowest-numbered low row is the one kept.
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (row_low[r]) row_sel = 2'(r);
        end
        col_pos = {row_sel, col_idx_q};

        div_cnt_d = sample ? '0 : div_cnt_q + 1'b1;
        col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
        col_out_d = ~(4'b0001 << col_idx_d);

        hit_d = hit_q;
        pos_d = pos_q;
        if (sample) begin
            if (col_idx_q == 2'(NUM_COLS - 1)) begin
                hit_d = 1'b0;
                pos_d = 4'd0;
            end else if (!hit_q && col_hit) begin
                hit_d = 1'b1;
                pos_d = col_pos;
            end
        end

        frame_done = sample && (col_idx_q == 2'(NUM_COLS - 1));
        frame_hit  = hit_q || col_hit;
        frame_pos  = hit_q ? pos_q : col_pos;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_s1_q  <= 4'hF;
            row_s2_q  <= 4'hF;
            div_cnt_q <= '0;
            col_idx_q <= 2'd0;
            col_out_q <= COL_RESET;
            hit_q     <= 1'b0;
            pos_q     <= 4'd0;
        end else begin
            row_s1_q  <= row_in;
            row_s2_q  <= row_s1_q;
            div_cnt_q <= div_cnt_d;
            col_idx_q <= col_idx_d;
            col_out_q <= col_out_d;
            hit_q     <= hit_d;
            pos_q     <= pos_d;
        end
    end

    assign col_out = col_out_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner top: column scanner plus debounce FSM and strobe outputs.
// Build option: KEYPAD_LOCK_EN swallows accepts while key_lock is high.
//
//  state     | meaning
//  IDLE      | no key down
//  CAND      | key seen, counting identical frames before accepting
//  PRESSED   | key accepted and still down
//  RELEASING | key gone, counting empty frames before reporting release
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    input  logic       key_lock,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_enable,
    output logic       key_func,
    output logic       key_held,
    output logic       key_release
);

    localparam logic [3:0] DB_LIM = 4'(DEBOUNCE_FRAMES);

    logic       frame_done, frame_hit;
    logic [3:0] frame_pos;

    key_state_e state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] code_q, code_d;
    logic       enable_q, enable_d;
    logic       func_q, func_d;
    logic       held_q, held_d;
    logic       release_q, release_d;

    logic       accept;
    logic [3:0] accept_pos;
    logic       swallow;

    keypad_col_scanner #(
        .SCAN_DIV(SCAN_DIV)
    ) u_col_scanner (
        .clk        (clk),
        .reset      (reset),
        .row_in     (row_in),
        .col_out    (col_out),
        .frame_done (frame_done),
        .frame_hit  (frame_hit),
        .frame_pos  (frame_pos)
    );

`ifdef KEYPAD_LOCK_EN
    assign swallow = key_lock;
`else
    logic unused_key_lock;
    assign unused_key_lock = key_lock;
    assign swallow         = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        accept_pos = cand_q;
        release_d  = 1'b0;

        if (frame_done) begin
            unique case (state_q)
                IDLE: begin
                    if (frame_hit) begin
                        cand_d = frame_pos;
                        cnt_d  = 4'd1;
                        if (DB_LIM <= 4'd1) begin
                            state_d    = PRESSED;
                            accept     = 1'b1;
                            accept_pos = frame_pos;
                        end else begin
                            state_d = CAND;
                        end
                    end
                end
                CAND: begin
                    if (!frame_hit) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else if (frame_pos != cand_q) begin
                        cand_d = frame_pos;
                        cnt_d  = 4'd1;
                    end else begin
                        cnt_d = sat_inc(cnt_q, DB_LIM);
                        if (cnt_d >= DB_LIM) begin
                            state_d    = PRESSED;
                            accept     = 1'b1;
                            accept_pos = cand_q;
                        end
                    end
                end
                PRESSED: begin
                    if (!frame_hit) begin
                        cnt_d = 4'd1;
                        if (DB_LIM <= 4'd1) begin
                            state_d   = IDLE;
                            cnt_d     = 4'd0;
                            release_d = 1'b1;
                        end else begin
                            state_d = RELEASING;
                        end
                    end
                end
                RELEASING: begin
                    if (frame_hit) begin
                        state_d = PRESSED;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = sat_inc(cnt_q, DB_LIM);
                        if (cnt_d >= DB_LIM) begin
                            state_d   = IDLE;
                            cnt_d     = 4'd0;
                            release_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        enable_d = accept && !swallow && (accept_pos != KEY_FUNC_POS);
        func_d   = accept && !swallow && (accept_pos == KEY_FUNC_POS);
        code_d   = enable_d ? accept_pos + 4'd1 : code_q;
        held_d   = (state_d == PRESSED) || (state_d == RELEASING);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cand_q    <= 4'd0;
            cnt_q     <= 4'd0;
            code_q    <= 4'd0;
            enable_q  <= 1'b0;
            func_q    <= 1'b0;
            held_q    <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            enable_q  <= enable_d;
            func_q    <= func_d;
            held_q    <= held_d;
            release_q <= release_d;
        end
    end

    assign key_code    = code_q;
    assign key_enable  = enable_q;
    assign key_func    = func_q;
    assign key_held    = held_q;
    assign key_release = release_q;

endmodule
